// File: rtl/usr_sequencer_if.sv
// rtl/usr_sequencer_if.sv - command and shift-register pin bundle for usr_sequencer
//
// Groups the host-side command handshake, the response and status signals, and
// the pins of the controlled universal shift register.
//   cmd_valid/cmd_ready   command handshake (host -> sequencer)
//   cmd_op/data/count     command fields, sampled on the accept edge
//   line_in               serial source used by RX_R shifts
//   sr_mode/sr_pin/sr_sin drive to the shift register (sequencer -> register)
//   sr_q                  shift register parallel output (register -> sequencer)
//   busy/done/rsp_data    status and captured result (sequencer -> host)
// Modport slave is the sequencer's view; master is the host/environment view.

interface usr_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CW-1:0]    cmd_count;
    logic             line_in;
    logic [2:0]       sr_mode;
    logic [WIDTH-1:0] sr_pin;
    logic             sr_sin;
    logic [WIDTH-1:0] sr_q;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rsp_data;

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_count,
        input  line_in,
        input  sr_q,
        output cmd_ready,
        output sr_mode,
        output sr_pin,
        output sr_sin,
        output busy,
        output done,
        output rsp_data
    );

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_count,
        output line_in,
        output sr_q,
        input  cmd_ready,
        input  sr_mode,
        input  sr_pin,
        input  sr_sin,
        input  busy,
        input  done,
        input  rsp_data
    );
endinterface

// File: rtl/usr_sequencer.sv
// rtl/usr_sequencer.sv - command sequencer for a 4-bit universal shift register
//
// Accepts one command at a time and plays it out as a per-cycle MODE sequence
// on the shift register, then captures the register output and pulses done.
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   usr_sequencer_if.slave: command handshake, register pins, status
// Commands (cmd_op): 0 TX_R load+shift right, 1 TX_L load+shift left,
//                    2 RX_R shift right from line_in, 3 CLR.
// Register MODE: 0 hold, 1 shift right, 2 shift left, 3 load, 4 clear.

module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic            clk,
    input  logic            rst,
    usr_sequencer_if.slave  bus
);

    localparam logic [1:0] OP_TX_R = 2'd0;
    localparam logic [1:0] OP_TX_L = 2'd1;
    localparam logic [1:0] OP_RX_R = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    localparam logic [2:0] MODE_HOLD  = 3'd0;
    localparam logic [2:0] MODE_SHR   = 3'd1;
    localparam logic [2:0] MODE_SHL   = 3'd2;
    localparam logic [2:0] MODE_LOAD  = 3'd3;
    localparam logic [2:0] MODE_CLEAR = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_remain;
    logic             r_done;
    logic [WIDTH-1:0] r_rsp;

    logic             w_ready;
    logic             w_accept;
    logic [2:0]       w_mode;
    logic [WIDTH-1:0] w_pin;
    logic             w_sin;

    // Ready drops combinationally with rst so a command presented during reset
    // is never taken.
    assign w_ready  = (r_state == S_IDLE) & ~rst;
    assign w_accept = bus.cmd_valid & w_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command latch, remaining-count, completion capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_TX_R;
            r_data   <= '0;
            r_remain <= '0;
            r_done   <= 1'b0;
            r_rsp    <= '0;
        end else begin
            // done is high exactly in the cycle after DONE, i.e. the first IDLE cycle
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_rsp <= bus.sr_q;
            end
            if (w_accept) begin
                r_op     <= bus.cmd_op;
                r_data   <= bus.cmd_data;
                r_remain <= bus.cmd_count;
            end else if (r_state == S_SHIFT) begin
                r_remain <= r_remain - 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.cmd_op)
                        OP_TX_R, OP_TX_L: w_next = S_LOAD;
                        OP_RX_R:          w_next = (bus.cmd_count != '0) ? S_SHIFT : S_DONE;
                        default:          w_next = S_CLEAR;
                    endcase
                end
            end
            S_LOAD: begin
                // r_remain still holds the full count here; SHIFT has not run yet
                w_next = (r_remain != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                // Remaining is never 0 on entry; <= 1 also guards against a wrap
                if (r_remain <= CW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_CLEAR: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decode; sr_sin is the only path straight from an input
    always_comb begin
        w_mode = MODE_HOLD;
        w_pin  = '0;
        w_sin  = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_mode = MODE_LOAD;
                w_pin  = r_data;
            end
            S_SHIFT: begin
                w_mode = (r_op == OP_TX_L) ? MODE_SHL : MODE_SHR;
                w_sin  = (r_op == OP_RX_R) ? bus.line_in : 1'b0;
            end
            S_CLEAR: w_mode = MODE_CLEAR;
            default: w_mode = MODE_HOLD;
        endcase
    end

    assign bus.cmd_ready = w_ready;
    assign bus.sr_mode   = w_mode;
    assign bus.sr_pin    = w_pin;
    assign bus.sr_sin    = w_sin;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.rsp_data  = r_rsp;

endmodule
